// File: rtl/bmu_req_arbiter.sv
// Two-requester front end for a single BMU: round-robin issue, a 2-stage tag
// pipeline routing each result back to its owner, and a flush/drain handshake.
module bmu_req_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [63:0] req_a,
    input  logic [63:0] req_b,
    input  logic [45:0] req_ap,
    input  logic [1:0]  req_csr_ren,
    input  logic [63:0] req_csr_rddata,
    output logic        bmu_rst_l,
    output logic        bmu_scan_mode,
    output logic        bmu_valid_in,
    output logic [31:0] bmu_a_in,
    output logic [31:0] bmu_b_in,
    output logic [22:0] bmu_ap,
    output logic        bmu_csr_ren_in,
    output logic [31:0] bmu_csr_rddata_in,
    input  logic [31:0] bmu_result_ff,
    input  logic        bmu_error,
    output logic [1:0]  resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_error,
    input  logic        flush_req,
    output logic        flush_done,
    output logic [7:0]  err_count
);

    typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_DRAIN} state_t;

    state_t      state_reg, state_next;
    logic        init_cnt_reg, init_cnt_next;
    logic        last_grant_reg;
    logic        s1_valid_reg, s1_owner_reg;
    logic        s2_valid_reg, s2_owner_reg;
    logic [31:0] bmu_a_reg, bmu_b_reg, bmu_csr_rddata_reg;
    logic [22:0] bmu_ap_reg;
    logic        bmu_csr_ren_reg;
    logic [7:0]  err_count_reg;

    logic [31:0] a_arr [2];
    logic [31:0] b_arr [2];
    logic [22:0] ap_arr [2];
    logic [31:0] csr_rd_arr [2];
    logic [1:0]  grant;
    logic        grant_sel;
    logic        fire;
    logic        winner;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_unpack
            assign a_arr[gi]      = req_a[gi*32 +: 32];
            assign b_arr[gi]      = req_b[gi*32 +: 32];
            assign ap_arr[gi]     = req_ap[gi*23 +: 23];
            assign csr_rd_arr[gi] = req_csr_rddata[gi*32 +: 32];
        end
    endgenerate

    // On contention the requester that did not win last time goes first.
    always_comb begin
        grant_sel = req_valid[1];
        if (req_valid == 2'b11)
            grant_sel = ~last_grant_reg;
        grant = 2'b00;
        if (req_valid != 2'b00)
            grant = grant_sel ? 2'b10 : 2'b01;
    end

    always_comb begin
        state_next    = state_reg;
        init_cnt_next = init_cnt_reg;
        req_ready     = 2'b00;
        flush_done    = 1'b0;
        bmu_rst_l     = 1'b1;
        case (state_reg)
            ST_INIT: begin
                bmu_rst_l = 1'b0;
                if (init_cnt_reg) begin
                    state_next    = ST_RUN;
                    init_cnt_next = 1'b0;
                end else begin
                    init_cnt_next = 1'b1;
                end
            end
            ST_RUN: begin
                // A flush wins over any pending request in the same cycle.
                if (flush_req)
                    state_next = ST_DRAIN;
                else if (!rst)
                    req_ready = grant;
            end
            ST_DRAIN: begin
                if (!s1_valid_reg && !s2_valid_reg) begin
                    flush_done = 1'b1;
                    state_next = ST_RUN;
                end
            end
            default: state_next = ST_INIT;
        endcase
    end

    assign fire   = |(req_valid & req_ready);
    assign winner = req_ready[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg          <= ST_INIT;
            init_cnt_reg       <= 1'b0;
            last_grant_reg     <= 1'b1;
            s1_valid_reg       <= 1'b0;
            s1_owner_reg       <= 1'b0;
            s2_valid_reg       <= 1'b0;
            s2_owner_reg       <= 1'b0;
            bmu_a_reg          <= '0;
            bmu_b_reg          <= '0;
            bmu_ap_reg         <= '0;
            bmu_csr_ren_reg    <= 1'b0;
            bmu_csr_rddata_reg <= '0;
            err_count_reg      <= '0;
        end else begin
            state_reg    <= state_next;
            init_cnt_reg <= init_cnt_next;
            s1_valid_reg <= fire;
            s2_valid_reg <= s1_valid_reg;
            s2_owner_reg <= s1_owner_reg;
            if (fire) begin
                last_grant_reg     <= winner;
                s1_owner_reg       <= winner;
                bmu_a_reg          <= a_arr[winner];
                bmu_b_reg          <= b_arr[winner];
                bmu_ap_reg         <= ap_arr[winner];
                bmu_csr_ren_reg    <= req_csr_ren[winner];
                bmu_csr_rddata_reg <= csr_rd_arr[winner];
            end
            if (s2_valid_reg && bmu_error && err_count_reg != 8'hFF)
                err_count_reg <= err_count_reg + 8'd1;
        end
    end

    // Stage 1 of the tag pipeline is exactly the issue strobe.
    assign bmu_valid_in      = s1_valid_reg;
    assign bmu_scan_mode     = 1'b0;
    assign bmu_a_in          = bmu_a_reg;
    assign bmu_b_in          = bmu_b_reg;
    assign bmu_ap            = bmu_ap_reg;
    assign bmu_csr_ren_in    = bmu_csr_ren_reg;
    assign bmu_csr_rddata_in = bmu_csr_rddata_reg;

    assign resp_valid = s2_valid_reg ? (s2_owner_reg ? 2'b10 : 2'b01) : 2'b00;
    assign resp_data  = bmu_result_ff;
    assign resp_error = bmu_error;
    assign err_count  = err_count_reg;

endmodule

// File: tb/tb_bmu_req_arbiter.sv
// Directed bench for bmu_req_arbiter with a simple adder standing in for the BMU.
module tb_bmu_req_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_a, req_b;
    logic [45:0] req_ap;
    logic [1:0]  req_csr_ren;
    logic [63:0] req_csr_rddata;
    logic        bmu_rst_l, bmu_scan_mode, bmu_valid_in;
    logic [31:0] bmu_a_in, bmu_b_in;
    logic [22:0] bmu_ap;
    logic        bmu_csr_ren_in;
    logic [31:0] bmu_csr_rddata_in;
    logic [31:0] bmu_result_ff = '0;
    logic        bmu_error = 1'b0;
    logic [1:0]  resp_valid;
    logic [31:0] resp_data;
    logic        resp_error;
    logic        flush_req;
    logic        flush_done;
    logic [7:0]  err_count;
    logic        err_inj;

    int checks = 0;
    int failures = 0;

    bmu_req_arbiter dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_ap(req_ap),
        .req_csr_ren(req_csr_ren), .req_csr_rddata(req_csr_rddata),
        .bmu_rst_l(bmu_rst_l), .bmu_scan_mode(bmu_scan_mode),
        .bmu_valid_in(bmu_valid_in), .bmu_a_in(bmu_a_in), .bmu_b_in(bmu_b_in),
        .bmu_ap(bmu_ap), .bmu_csr_ren_in(bmu_csr_ren_in),
        .bmu_csr_rddata_in(bmu_csr_rddata_in),
        .bmu_result_ff(bmu_result_ff), .bmu_error(bmu_error),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_error(resp_error),
        .flush_req(flush_req), .flush_done(flush_done), .err_count(err_count)
    );

    always #5 clk = ~clk;

    // BMU stand-in: result and error registered one cycle after the issue strobe.
    always @(posedge clk) begin
        if (bmu_valid_in) begin
            bmu_result_ff <= bmu_a_in + bmu_b_in;
            bmu_error     <= err_inj;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [1:0]  grant_exp [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [31:0] a_exp     [4] = '{32'd0, 32'd101, 32'd2, 32'd103};

    initial begin
        rst = 1'b1; req_valid = 2'b00; req_a = '0; req_b = '0; req_ap = '0;
        req_csr_ren = '0; req_csr_rddata = '0; flush_req = 1'b0; err_inj = 1'b0;
        tick; tick;
        req_valid = 2'b11;
        #1;
        chk("rst_bmu_rst_l", bmu_rst_l, 0);
        chk("rst_valid_in", bmu_valid_in, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_flush_done", flush_done, 0);
        chk("rst_bmu_a", bmu_a_in, 0);
        chk("rst_ready", req_ready, 0);
        chk("scan_mode", bmu_scan_mode, 0);

        // Two INIT cycles after reset release.
        rst = 1'b0;
        #1;
        chk("init0_rst_l", bmu_rst_l, 0);
        chk("init0_ready", req_ready, 0);
        tick;
        chk("init1_rst_l", bmu_rst_l, 0);
        chk("init1_ready", req_ready, 0);
        tick;
        chk("run_rst_l", bmu_rst_l, 1);

        // Contention for 4 cycles: grants 0,1,0,1 and matching responses.
        for (int k = 0; k < 8; k++) begin
            if (k < 4) begin
                req_valid = 2'b11;
                req_a = {32'(100 + k), 32'(k)};
                req_b = {32'd1000, 32'd1000};
                req_ap = {23'd2, 23'd2};
            end else begin
                req_valid = 2'b00;
            end
            #1;
            if (k < 4) chk($sformatf("rr_grant%0d", k), req_ready, grant_exp[k]);
            if (k >= 1 && k <= 4) begin
                chk($sformatf("rr_issue%0d", k - 1), bmu_valid_in, 1);
                chk($sformatf("rr_a%0d", k - 1), bmu_a_in, a_exp[k - 1]);
            end
            if (k >= 2 && k <= 5) begin
                chk($sformatf("rr_resp%0d", k - 2), resp_valid, grant_exp[k - 2]);
                chk($sformatf("rr_data%0d", k - 2), resp_data, a_exp[k - 2] + 32'd1000);
            end
            if (k == 6) chk("rr_idle", resp_valid, 0);
            tick;
        end

        // Single req0 add: 5 + 3.
        req_valid = 2'b01; req_a = {32'd0, 32'd5}; req_b = {32'd0, 32'd3};
        req_ap = {23'd0, 23'd2}; req_csr_ren = 2'b01; req_csr_rddata = {32'd0, 32'hABCD};
        #1;
        chk("add_ready", req_ready, 2'b01);
        tick;
        req_valid = 2'b00; req_a = '0; req_b = '0; req_ap = '0;
        req_csr_ren = '0; req_csr_rddata = '0;
        #1;
        chk("add_issue", bmu_valid_in, 1);
        chk("add_a", bmu_a_in, 5);
        chk("add_b", bmu_b_in, 3);
        chk("add_ap", bmu_ap, 2);
        chk("add_csr_ren", bmu_csr_ren_in, 1);
        chk("add_csr_rd", bmu_csr_rddata_in, 32'hABCD);
        chk("add_noresp", resp_valid, 0);
        tick;
        chk("add_resp", resp_valid, 2'b01);
        chk("add_data", resp_data, 8);
        chk("add_valid_low", bmu_valid_in, 0);
        chk("add_hold_a", bmu_a_in, 5);
        chk("add_hold_csr", bmu_csr_rddata_in, 32'hABCD);
        tick;
        chk("add_resp_end", resp_valid, 0);

        // req1 alone.
        req_valid = 2'b10; req_a = {32'd1, 32'd0}; req_b = {32'd1, 32'd0};
        #1;
        chk("r1_ready", req_ready, 2'b10);
        tick;
        req_valid = 2'b00;
        tick; tick;

        // Flush with two ops in flight.
        req_valid = 2'b01; req_a = {32'd0, 32'd7}; req_b = {32'd0, 32'd1};
        #1;
        chk("fl_ready0", req_ready, 2'b01);
        tick;
        req_a = {32'd0, 32'd9};
        #1;
        chk("fl_ready1", req_ready, 2'b01);
        tick;
        flush_req = 1'b1;
        #1;
        chk("fl_ready_blk", req_ready, 0);
        chk("fl_resp0", resp_valid, 2'b01);
        chk("fl_data0", resp_data, 8);
        tick;
        #1;
        chk("fl_drain_ready", req_ready, 0);
        chk("fl_resp1", resp_valid, 2'b01);
        chk("fl_data1", resp_data, 10);
        chk("fl_done_early", flush_done, 0);
        tick;
        flush_req = 1'b0;
        #1;
        chk("fl_done", flush_done, 1);
        chk("fl_done_ready", req_ready, 0);
        chk("fl_done_noresp", resp_valid, 0);
        tick;
        chk("fl_run_ready", req_ready, 2'b01);
        chk("fl_done_pulse", flush_done, 0);
        tick;
        req_valid = 2'b00;
        tick; tick; tick;

        // 300 back-to-back error responses: err_count saturates.
        err_inj = 1'b1;
        req_valid = 2'b01; req_a = '0; req_b = '0;
        for (int k = 0; k < 300; k++) begin
            #1;
            if (k == 5) begin
                chk("err_resp", resp_valid, 2'b01);
                chk("err_flag", resp_error, 1);
            end
            if (k == 10) chk("err_cnt8", err_count, 8);
            if (k == 260) chk("err_cnt_sat", err_count, 255);
            tick;
        end
        req_valid = 2'b00;
        tick; tick; tick;
        chk("err_cnt_hold", err_count, 255);
        err_inj = 1'b0;
        tick;

        // Reset one cycle after a transfer discards it.
        req_valid = 2'b01; req_a = {32'd0, 32'd5}; req_b = {32'd0, 32'd3};
        #1;
        chk("mr_ready", req_ready, 2'b01);
        tick;
        req_valid = 2'b00; rst = 1'b1;
        #1;
        chk("mr_issue", bmu_valid_in, 1);
        tick;
        rst = 1'b0; req_valid = 2'b01;
        #1;
        chk("mr_resp", resp_valid, 0);
        chk("mr_valid_in", bmu_valid_in, 0);
        chk("mr_rst_l", bmu_rst_l, 0);
        chk("mr_a", bmu_a_in, 0);
        chk("mr_b", bmu_b_in, 0);
        chk("mr_err", err_count, 0);
        chk("mr_flush_done", flush_done, 0);
        chk("mr_ready", req_ready, 0);
        tick;
        chk("mr_resp2", resp_valid, 0);
        chk("mr_rst_l2", bmu_rst_l, 0);
        tick;
        req_valid = 2'b11;
        #1;
        chk("mr_rst_l_run", bmu_rst_l, 1);
        chk("mr_rr_reset", req_ready, 2'b01);
        tick;
        req_valid = 2'b00;
        tick; tick;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bmu_req_arbiter.md
BMU_REQ_ARBITER -- requirements
Module: bmu_req_arbiter

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset:
- clk  in  1  rising-edge clock for all state.
- rst  in  1  synchronous, active-high reset.
REQ-002 SHALL expose the requester ports, packed as {req1,req0}:
- req_valid  in  2  request present, per requester.
- req_ready  out  2  grant; a transfer occurs when valid and ready are both 1.
- req_a  in  64  operand A, 32b per requester.
- req_b  in  64  operand B, 32b per requester.
- req_ap  in  46  23b BMU opcode vector per requester; bit 22 = csr_write, bit 0 = gorc.
- req_csr_ren  in  2  CSR read enable per requester.
- req_csr_rddata  in  64  CSR read data, 32b per requester.
REQ-003 SHALL expose the BMU-side ports:
- bmu_rst_l  out  1  BMU reset, active-low.
- bmu_scan_mode  out  1  constant 0.
- bmu_valid_in  out  1  issue strobe.
- bmu_a_in  out  32  operand A to BMU.
- bmu_b_in  out  32  operand B to BMU.
- bmu_ap  out  23  opcode vector to BMU.
- bmu_csr_ren_in  out  1  CSR read enable to BMU.
- bmu_csr_rddata_in  out  32  CSR read data to BMU.
- bmu_result_ff  in  32  BMU result; valid 1 cycle after bmu_valid_in.
- bmu_error  in  1  BMU error flag; qualified like bmu_result_ff.
REQ-004 SHALL expose the response and control ports:
- resp_valid  out  2  one-hot response strobe, indexed by the owning requester.
- resp_data  out  32  response data.
- resp_error  out  1  response error flag.
- flush_req  in  1  drain request.
- flush_done  out  1  1-cycle pulse when the drain completes.
- err_count  out  8  saturating count of error responses.

Function
REQ-005 SHALL implement FSM states INIT, RUN and DRAIN.
REQ-006 INIT SHALL hold bmu_rst_l=0 for exactly 2 cycles after rst deasserts, then move to RUN with bmu_rst_l=1.
REQ-007 req_ready SHALL be 0 in every state other than RUN.
REQ-008 In RUN, req_ready SHALL be combinational and at most one-hot:
- Only req0 valid: grant 0.
- Only req1 valid: grant 1.
- Both valid: grant the requester not granted most recently (round-robin pointer).
REQ-009 The round-robin pointer SHALL update only on a completed transfer.
REQ-010 A transfer at cycle t SHALL register the winner's a, b, ap, csr_ren and csr_rddata onto the bmu_* outputs, with bmu_valid_in=1 at t+1.
REQ-011 Issue SHALL sustain 1 operation per cycle back-to-back.
REQ-012 Without a transfer, bmu_valid_in SHALL be 0 and the bmu_a_in, bmu_b_in, bmu_ap, bmu_csr_ren_in and bmu_csr_rddata_in outputs SHALL hold their previous values.
REQ-013 A 2-stage tag pipeline (valid plus owner) SHALL track each issue; the response SHALL appear at t+2:
- resp_valid[owner]=1.
- resp_data=bmu_result_ff.
- resp_error=bmu_error.
REQ-014 resp_valid SHALL be all-zero when stage 2 is empty, and resp_data and resp_error are don't-care in that case.
REQ-015 Responses SHALL have no backpressure; requesters SHALL always accept them.
REQ-016 err_count SHALL increment by 1 on each response with resp_error=1 and saturate at 255.
REQ-017 RUN SHALL move to DRAIN when flush_req=1; req_ready SHALL be 0 in the same cycle.
REQ-018 DRAIN SHALL wait until both tag stages are empty, then pulse flush_done for 1 cycle and return to RUN on the next cycle.
REQ-019 flush_req SHALL be ignored in INIT and DRAIN.
REQ-020 In-flight operations SHALL complete normally during DRAIN.
REQ-021 flush_req asserted in the same cycle as a pending request SHALL take priority: no transfer occurs in that cycle.
REQ-022 Issue order SHALL equal response order; no reordering.

Reset
REQ-023 On rst=1, at the next edge the block SHALL:
- Enter INIT with the init counter at 0.
- Drive bmu_rst_l=0, bmu_valid_in=0 and all bmu_* data outputs to 0.
- Drive resp_valid=0, flush_done=0 and err_count=0.
- Clear both tag stages.
- Set the round-robin pointer so that req0 wins the first contention.
REQ-024 rst asserted mid-operation SHALL discard all in-flight tags; no resp_valid SHALL be produced for operations issued before the reset.
REQ-025 rst SHALL take priority over flush_req and over any transfer.

Verification
REQ-026 Reset release -> bmu_rst_l=0 for 2 cycles, then 1; req_ready=0 until RUN.
REQ-027 req0 alone, a=5, b=3, ap=add bit -> bmu_valid_in at t+1; resp_valid=2'b01 with resp_data=8 at t+2.
REQ-028 Both requesters valid for 4 cycles -> grants 0,1,0,1, back-to-back; responses strobe 01,10,01,10 from t+2.
REQ-029 flush_req with 2 ops in flight -> req_ready=0 immediately; both responses delivered; flush_done pulses in the cycle after the last response; RUN resumes the next cycle.
REQ-030 BMU error=1 on 300 consecutive responses -> err_count=255 and held.
REQ-031 rst asserted 1 cycle after a transfer -> no resp_valid; all outputs at reset values next cycle.
